// File: rtl/sprite_pipe_renderer.sv
// Sprite pixel generator: 3-stage pipeline from scan position to colour/opaque, reading an external sync ROM.
// Optional `SPRITE_SCALE2_EN doubles the on-screen box so each texel covers 2x2 pixels.
module sprite_pipe_renderer #(
  parameter int          SPR_W   = 34,
  parameter int          SPR_H   = 36,
  parameter int          FRAMES  = 14,
  parameter int          FRAME_W = 4,
  parameter int          ADDR_W  = 15,
  parameter logic [15:0] KEY     = 16'hffff
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         col,
  input  logic [8:0]         row,
  input  logic [9:0]         posx,
  input  logic [8:0]         posy,
  input  logic [FRAME_W-1:0] frame_sel,
  input  logic               mirror,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [15:0]        rom_data,
  output logic [15:0]        color,
  output logic               opaque
);

`ifdef SPRITE_SCALE2_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif
  localparam int BOX_W    = SPR_W << SCALE_SH;
  localparam int BOX_H    = SPR_H << SCALE_SH;
  localparam int FRAME_SZ = SPR_W * SPR_H;

  logic [9:0]         px_q;
  logic [8:0]         py_q;
  logic [FRAME_W-1:0] frame_q;
  logic               mirror_q;
  logic               v1, v2;

  logic               at_origin;
  logic [FRAME_W-1:0] frame_clamp;
  logic [9:0]         px;
  logic [8:0]         py;
  logic [FRAME_W-1:0] frame;
  logic               mir;
  logic [10:0]        col_end;
  logic [9:0]         row_end;
  logic               in_box;
  logic [9:0]         dx_box, dx, xm;
  logic [8:0]         dy_box, dy;
  logic [ADDR_W-1:0]  addr_c;

  // The (0,0) pixel must already see the values being captured on this edge.
  always_comb begin
    at_origin   = (row == 9'd0) && (col == 10'd0);
    frame_clamp = (32'(frame_sel) >= FRAMES) ? FRAME_W'(FRAMES - 1) : frame_sel;
    px          = at_origin ? posx        : px_q;
    py          = at_origin ? posy        : py_q;
    frame       = at_origin ? frame_clamp : frame_q;
    mir         = at_origin ? mirror      : mirror_q;
  end

  // Box ends are one bit wider than the scan counters so a sprite near the edge clips instead of wrapping.
  always_comb begin
    col_end = {1'b0, px} + 11'(BOX_W);
    row_end = {1'b0, py} + 10'(BOX_H);
    in_box  = (col >= px) && ({1'b0, col} < col_end) &&
              (row >= py) && ({1'b0, row} < row_end);
    dx_box  = col - px;
    dy_box  = row - py;
    dx      = dx_box >> SCALE_SH;
    dy      = dy_box >> SCALE_SH;
    xm      = mir ? (10'(SPR_W - 1) - dx) : dx;
    addr_c  = ADDR_W'(32'(frame) * 32'(FRAME_SZ) + 32'(dy) * 32'(SPR_W) + 32'(xm));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_q     <= '0;
      py_q     <= '0;
      frame_q  <= '0;
      mirror_q <= 1'b0;
      rom_addr <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      color    <= KEY;
      opaque   <= 1'b0;
    end else begin
      if (at_origin) begin
        px_q     <= posx;
        py_q     <= posy;
        frame_q  <= frame_clamp;
        mirror_q <= mirror;
      end
      if (in_box)
        rom_addr <= addr_c;
      v1 <= in_box;
      v2 <= v1;
      // A texel equal to KEY is still reported opaque; the mixer decides what to do with it.
      if (v2) begin
        color  <= rom_data;
        opaque <= 1'b1;
      end else begin
        color  <= KEY;
        opaque <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pipe_renderer.sv
// Scoreboard bench for sprite_pipe_renderer: driver queues hand-computed expectations, monitor checks rom_addr at +1 and color/opaque at +3.
module tb_sprite_pipe_renderer;
  localparam logic [15:0] KEY = 16'hffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  col = '0;
  logic [8:0]  row = '0;
  logic [9:0]  posx = 10'd100;
  logic [8:0]  posy = 9'd50;
  logic [3:0]  frame_sel = '0;
  logic        mirror = 1'b0;
  logic [14:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] color;
  logic        opaque;

  sprite_pipe_renderer dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .posx      (posx),
    .posy      (posy),
    .frame_sel (frame_sel),
    .mirror    (mirror),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .color     (color),
    .opaque    (opaque)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: word = 0x1234 + address.
  always @(posedge clk) rom_data <= 16'h1234 + 16'(rom_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic [14:0] addr;
    logic        opq;
    logic [15:0] color;
  } exp_t;

  exp_t aq[$];
  exp_t cq[$];
  exp_t me;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int c, input int r, input logic exp_o, input int exp_a,
                       input logic r_in = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r_in;
    col = 10'(c);
    row = 9'(r);
    e.stamp = cyc;
    e.addr  = 15'(exp_a);
    e.opq   = exp_o;
    e.color = exp_o ? (16'h1234 + 16'(exp_a)) : KEY;
    aq.push_back(e);
    cq.push_back(e);
  endtask

  always @(negedge clk) begin
    while (aq.size() > 0 && aq[0].stamp + 1 == cyc) begin
      me = aq.pop_front();
      check($sformatf("rom_addr@%0d", me.stamp), 32'(rom_addr), 32'(me.addr));
    end
    while (cq.size() > 0 && cq[0].stamp + 3 == cyc) begin
      me = cq.pop_front();
      check($sformatf("opaque@%0d", me.stamp), 32'(opaque), 32'(me.opq));
      check($sformatf("color@%0d", me.stamp), 32'(color), 32'(me.color));
    end
  end

  initial begin
    @(posedge clk);
    @(negedge clk);
    check("reset_color", 32'(color), 32'(KEY));
    check("reset_opaque", 32'(opaque), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);

    drive(0, 0, 0, 0);
`ifdef SPRITE_SCALE2_EN
    drive(100, 50, 1, 0);
    drive(101, 51, 1, 0);
    drive(102, 51, 1, 1);
    drive(167, 121, 1, 1223);
    drive(168, 50, 0, 1223);
    drive(100, 122, 0, 1223);
`else
    drive(100, 50, 1, 0);
    drive(133, 85, 1, 1223);
    drive(134, 85, 0, 1223);
    drive(99, 50, 0, 1223);
    drive(100, 85, 1, 1190);
    drive(100, 86, 0, 1190);

    // Frame/mirror changes mid-frame stay invisible until (0,0).
    frame_sel = 4'd2; mirror = 1'b1;
    drive(100, 50, 1, 0);
    drive(0, 0, 0, 0);
    drive(100, 50, 1, 2481);
    drive(133, 50, 1, 2448);
    drive(101, 51, 1, 2514);

    frame_sel = 4'd15;
    drive(0, 0, 0, 2514);
    drive(100, 50, 1, 15945);
    frame_sel = 4'd14; mirror = 1'b0;
    drive(0, 0, 0, 15945);
    drive(100, 50, 1, 15912);

    frame_sel = 4'd0;
    drive(0, 0, 0, 15912);
    drive(100, 60, 1, 340);
    posx = 10'd200;
    drive(100, 60, 1, 340);
    drive(200, 60, 0, 340);
    drive(0, 0, 0, 340);
    drive(200, 60, 1, 340);
    drive(233, 60, 1, 373);
    drive(100, 60, 0, 373);

    // Right/bottom edge clipping, no wrap to column/row 0.
    posx = 10'd1010;
    drive(0, 0, 0, 373);
    drive(1010, 50, 1, 0);
    drive(1023, 50, 1, 13);
    drive(0, 50, 0, 13);
    drive(19, 50, 0, 13);
    posy = 9'd500;
    drive(0, 0, 0, 13);
    drive(1012, 511, 1, 376);
    drive(1012, 0, 0, 376);

    // Reset mid-line kills in-flight pixels and clears the latch.
    posx = 10'd100; posy = 9'd50;
    drive(0, 0, 0, 376);
    drive(101, 50, 1, 1);
    drive(102, 50, 0, 2);
    drive(103, 50, 0, 3);
    drive(104, 50, 0, 0, 1'b1);
    drive(105, 50, 0, 0);
    drive(1, 1, 1, 35);
    drive(2, 1, 1, 36);
`endif
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(aq.size() + cq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_pipe_renderer.md
Name: sprite_pipe_renderer

Overview:
- Parametrised sprite pixel generator for the VGA path; successor to the fixed-size, fixed-14-frame Mario colour block.
- Sprite size, frame count and transparency key are parameters. All frames sit in one external synchronous ROM, indexed by frame number.
- Adds a fixed 3-cycle pipeline, a frame-boundary latch for position/frame/mirror (no tearing), horizontal mirroring, frame-index clamping and an opaque flag for the layer mixer.

Parameters:
- SPR_W, 34, sprite width in pixels.
- SPR_H, 36, sprite height in pixels.
- FRAMES, 14, number of animation frames stored back to back in ROM.
- FRAME_W, 4, width of frame_sel.
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= FRAMES*SPR_W*SPR_H.
- KEY, 16'hffff, transparent colour output outside the sprite box.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- col  in  10  VGA scan column
- row  in  9  VGA scan row
- posx  in  10  sprite left column
- posy  in  9  sprite top row
- frame_sel  in  FRAME_W  requested animation frame
- mirror  in  1  1 = draw horizontally flipped
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  16  ROM word; valid one clk after rom_addr
- color  out  16  pixel colour
- opaque  out  1  1 = color is a sprite pixel; 0 = color is KEY

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: color=KEY, opaque=0, rom_addr=0. Latched posx/posy/frame/mirror=0. Pipeline valid bits=0.
- Frame latch:
  - On any clk edge with row==0 && col==0, capture posx, posy, mirror and the clamped frame.
  - Clamped frame = FRAMES-1 when frame_sel>=FRAMES, else frame_sel.
  - Latched values hold for the whole video frame; input changes mid-frame have no visible effect until the next (0,0).
  - The pixel at (0,0) itself uses the newly captured values.
- Stage 1 (cycle N+1, registered):
  - in_box = col>=px && col<px+SPR_W && row>=py && row<py+SPR_H.
  - Sums are computed 11/10 bits wide, so a sprite extending past 1023/511 clips and never wraps.
  - dx = col-px; dy = row-py; x' = mirror ? SPR_W-1-dx : dx.
  - rom_addr <= frame*SPR_W*SPR_H + dy*SPR_W + x' when in_box; otherwise rom_addr holds its previous value.
  - v1 <= in_box.
- Stage 2 (cycle N+2): ROM presents rom_data; v2 <= v1.
- Stage 3 (cycle N+3): if v2, then color<=rom_data and opaque<=1; else color<=KEY and opaque<=0.
- Total latency: col/row to color/opaque is exactly 3 clk. The pipeline takes a new pixel every cycle with no stalls.
- Sprite pixels whose ROM value equals KEY still give opaque=1; the mixer decides.
- rst asserted mid-line: all outputs and valid bits return to reset values on that edge. The first valid colour appears 3 clk after the first in-box pixel following rst deassert.

Optional Feature:
- SPRITE_SCALE2_EN defined:
  - Box is 2*SPR_W x 2*SPR_H.
  - dx, dy are computed from the box offset then shifted right by 1 before mirroring and addressing, so each texel covers 2x2 pixels.
  - Latency unchanged.
- Undefined: 1:1 mapping exactly as above.

Test Plan:
- rst=1 for 2 clk, then rst=0 with col=0,row=0 -> color=16'hffff, opaque=0, rom_addr=0.
- posx=100,posy=50,frame_sel=0,mirror=0 latched at (0,0); drive col=100,row=50 at cycle N -> rom_addr=0 at N+1; ROM model returns 16'h1234 -> color=16'h1234, opaque=1 at N+3. col=133,row=85 -> rom_addr=1223. col=134 -> opaque=0 three cycles later.
- frame_sel=2, mirror=1, posx=100, posy=50; col=100,row=50 -> rom_addr=2*1224+33=2481. frame_sel=15 -> clamped to 13: rom_addr=13*1224+33=15945.
- Change posx from 100 to 200 mid-frame at row=60 -> col=100 pixels stay opaque until the next (0,0); afterwards col=200 is the sprite's left edge.
- posx=1010 -> col 1010..1023 opaque; col 0..19 on the same row opaque=0 (no wrap).
- Assert rst for 1 clk while streaming in-box pixels -> opaque=0 and color=KEY at that edge; opaque returns exactly 3 clk after the next in-box pixel. SPRITE_SCALE2_EN build: col=101,row=51 gives rom_addr 0, col=102 gives rom_addr 1.
